// File: rtl/fifo_pkg.sv
// Constants and helpers shared by the write and read sides of the async FIFO.
package fifo_pkg;
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  function automatic int ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// Valid/ready stream carrying words popped from the FIFO read side.
interface fifo_rd_stream_adapter_if #(parameter int DATA_SIZE = 8);
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_SIZE-1:0] m_data;

  modport master (output m_valid, m_data, input m_ready);
  modport slave  (input m_valid, m_data, output m_ready);
endinterface

// File: rtl/d_ff_async.sv
// Single-bit D flip-flop with asynchronous active-high clear.
module d_ff_async (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end
endmodule

// File: rtl/rd_latency_pipe.sv
// Valid-bit delay line matching the FIFO memory read latency.
module rd_latency_pipe #(
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic out_valid
);
  logic [READ_LATENCY:0] vld_pipe;

  assign vld_pipe[0] = in_valid;

  for (genvar i = 0; i < READ_LATENCY; i++) begin : g_stage
    d_ff_async u_ff (
      .clk (clk),
      .rst (rst),
      .d   (vld_pipe[i]),
      .q   (vld_pipe[i+1])
    );
  end

  assign out_valid = vld_pipe[READ_LATENCY];
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read-side consumer: credit-limited read enable, latency pipe and skid buffer
// feeding a valid/ready stream. Define RD_STREAM_CNT_EN to add the xfer_cnt output.
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE    = 8,
  parameter int READ_LATENCY = 1,
  parameter int SKID_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r_empty,
  input  logic [DATA_SIZE-1:0] r_data,
  output logic                 r_en,
`ifdef RD_STREAM_CNT_EN
  output logic [15:0]          xfer_cnt,
`endif
  fifo_rd_stream_adapter_if.master m
);
  localparam int          PW    = ptr_w(SKID_DEPTH);
  localparam int          AW    = PW - 1;
  localparam logic [PW:0] DEPTH = (PW+1)'(SKID_DEPTH);

  logic [DATA_SIZE-1:0] mem [SKID_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr, count, inflight;
  logic [PW:0]          occupancy;
  logic [DATA_SIZE-1:0] last_data;
  logic                 accept, retire, pop;

  assign count     = wr_ptr - rd_ptr;
  assign occupancy = {1'b0, inflight} + {1'b0, count};

  // Reads are credited against words in flight plus buffered words, so every
  // accepted read already owns a slot; a same-cycle pop is deliberately not credited.
  assign r_en   = ~rst & ~r_empty & (occupancy < DEPTH);
  assign accept = r_en & ~r_empty;

  assign m.m_valid = (count != '0);
  assign pop       = m.m_valid & m.m_ready;
  assign m.m_data  = m.m_valid ? mem[rd_ptr[AW-1:0]] : last_data;

  rd_latency_pipe #(.READ_LATENCY(READ_LATENCY)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .out_valid (retire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      inflight  <= '0;
      last_data <= '0;
    end else begin
      if (retire) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({accept, retire})
        2'b10:   inflight <= inflight + PW'(1);
        2'b01:   inflight <= inflight - PW'(1);
        default: ;
      endcase
      last_data <= m.m_data;
    end
  end

  // Storage needs no reset: an empty buffer never exposes it.
  always_ff @(posedge clk) begin
    if (retire) mem[wr_ptr[AW-1:0]] <= r_data;
  end

`ifdef RD_STREAM_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           xfer_cnt <= '0;
    else if (pop && xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

  assert property (@(posedge clk) disable iff (rst)
    !(retire && count == PW'(SKID_DEPTH)))
    else $error("skid buffer written while full");

  assert property (@(posedge clk)
    (READ_LATENCY >= READ_LATENCY_MIN) && (READ_LATENCY <= READ_LATENCY_MAX))
    else $error("READ_LATENCY out of range");
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: READ_LATENCY=1 and =2 instances, FIFO source model,
// sequence-number scoreboard checked every cycle, plus directed literal checks.
module tb_fifo_rd_stream_adapter;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          r_empty [2];
  logic [DW-1:0] r_data  [2];
  logic          r_en    [2];
  logic          mv      [2];
  logic          mr      [2];
  logic [DW-1:0] md      [2];
`ifdef RD_STREAM_CNT_EN
  logic [15:0]   xc      [2];
`endif

  fifo_rd_stream_adapter_if #(.DATA_SIZE(DW)) s0 ();
  fifo_rd_stream_adapter_if #(.DATA_SIZE(DW)) s1 ();

  assign mv[0] = s0.m_valid;
  assign md[0] = s0.m_data;
  assign s0.m_ready = mr[0];
  assign mv[1] = s1.m_valid;
  assign md[1] = s1.m_data;
  assign s1.m_ready = mr[1];

  fifo_rd_stream_adapter #(.DATA_SIZE(DW), .READ_LATENCY(1), .SKID_DEPTH(DEPTH)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .r_empty (r_empty[0]),
    .r_data  (r_data[0]),
    .r_en    (r_en[0]),
`ifdef RD_STREAM_CNT_EN
    .xfer_cnt(xc[0]),
`endif
    .m       (s0)
  );

  fifo_rd_stream_adapter #(.DATA_SIZE(DW), .READ_LATENCY(2), .SKID_DEPTH(DEPTH)) u_dut2 (
    .clk     (clk),
    .rst     (rst),
    .r_empty (r_empty[1]),
    .r_data  (r_data[1]),
    .r_en    (r_en[1]),
`ifdef RD_STREAM_CNT_EN
    .xfer_cnt(xc[1]),
`endif
    .m       (s1)
  );

  int n_chk, n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // FIFO source: word at position p is f_base + p; data appears on r_data with the DUT's latency.
  int            f_rd [2];
  int            f_wr [2];
  logic [DW-1:0] f_base [2];
  logic          force_empty [2];
  logic [DW-1:0] dp0 [2];
  int            acc_cnt [2];

  assign r_empty[0] = force_empty[0] | (f_rd[0] >= f_wr[0]);
  assign r_empty[1] = force_empty[1] | (f_rd[1] >= f_wr[1]);

  initial begin
    logic acc_e [2];
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) acc_e[i] = r_en[i] & ~r_empty[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (i == 1) r_data[i] = dp0[i];
        if (acc_e[i]) begin
          dp0[i] = f_base[i] + DW'(f_rd[i]);
          f_rd[i]++;
          acc_cnt[i]++;
        end
        if (i == 0) r_data[i] = dp0[i];
      end
    end
  end

  // Scoreboard: accepted reads get sequence numbers; a word is visible once
  // accept_edge + latency edges have passed, and leaves in order on pops.
  int            n_acc [2];
  int            n_pop [2];
  int            pop_cnt [2];
  int            acc_t [2][256];
  logic [DW-1:0] acc_v [2][256];
  logic [DW-1:0] last_d [2];
  int            edge_n;
`ifdef RD_STREAM_CNT_EN
  int            xfer_m [2];
`endif

  initial begin
    edge_n = 0;
    for (int i = 0; i < 2; i++) begin
      n_acc[i] = 0; n_pop[i] = 0; pop_cnt[i] = 0; last_d[i] = '0;
`ifdef RD_STREAM_CNT_EN
      xfer_m[i] = 0;
`endif
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic          e_valid, e_ren;
        logic [DW-1:0] e_data;
        if (rst) begin
          n_pop[i]  = n_acc[i];
          last_d[i] = '0;
`ifdef RD_STREAM_CNT_EN
          xfer_m[i] = 0;
`endif
        end
        e_valid = !rst && (n_pop[i] < n_acc[i]) && (acc_t[i][n_pop[i] & 255] + i + 1 <= edge_n);
        e_data  = e_valid ? acc_v[i][n_pop[i] & 255] : last_d[i];
        e_ren   = !rst && !r_empty[i] && (n_acc[i] - n_pop[i] < DEPTH);
        chk($sformatf("r_en%0d", i),    32'(r_en[i]), 32'(e_ren));
        chk($sformatf("m_valid%0d", i), 32'(mv[i]),   32'(e_valid));
        chk($sformatf("m_data%0d", i),  32'(md[i]),   32'(e_data));
`ifdef RD_STREAM_CNT_EN
        chk($sformatf("xfer_cnt%0d", i), 32'(xc[i]), 32'(xfer_m[i]));
`endif
        if (e_valid && mr[i]) begin
          n_pop[i]++;
          pop_cnt[i]++;
`ifdef RD_STREAM_CNT_EN
          if (xfer_m[i] < 65535) xfer_m[i]++;
`endif
        end
        last_d[i] = e_data;
        if (e_ren) begin
          acc_t[i][n_acc[i] & 255] = edge_n + 1;
          acc_v[i][n_acc[i] & 255] = f_base[i] + DW'(f_rd[i]);
          n_acc[i]++;
        end
      end
      chk("inflight2_le2", 32'(u_dut2.inflight <= 3'd2), 32'd1);
      chk("count2_le4",    32'(u_dut2.count <= 3'd4),    32'd1);
      edge_n++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int p0;
    n_chk = 0; n_err = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      force_empty[i] = (i == 1); f_rd[i] = 0; f_wr[i] = 0; f_base[i] = '0;
      mr[i] = 1'b0; r_data[i] = '0; dp0[i] = '0; acc_cnt[i] = 0;
    end
    f_base[0] = 8'h10; f_wr[0] = 8; mr[0] = 1'b1;

    // Reset held 3 cycles with a non-empty FIFO
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("rst_r_en",    32'(r_en[0]), 32'd0);
      chk("rst_m_valid", 32'(mv[0]),   32'd0);
      chk("rst_m_data",  32'(md[0]),   32'd0);
    end
    rst = 1'b0;
    #1;
    chk("rel_r_en", 32'(r_en[0]), 32'd1);

    // Streaming 0x10..0x17, latency 1
    tick(1);
    chk("first_lat", 32'(mv[0]), 32'd0);
    tick(1);
    for (int k = 0; k < 8; k++) begin
      chk("stream_valid", 32'(mv[0]), 32'd1);
      chk("stream_data",  32'(md[0]), 32'(16 + k));
      tick(1);
    end
    chk("stream_drain", 32'(mv[0]), 32'd0);
    chk("stream_reads", 32'(acc_cnt[0]), 32'd8);

    // Back-pressure: 10 words, m_ready low for 20 cycles
    mr[0] = 1'b0; acc_cnt[0] = 0; f_base[0] = 8'h40; f_rd[0] = 0; f_wr[0] = 10;
    tick(20);
    chk("bp_accepts", 32'(acc_cnt[0]),     32'd4);
    chk("bp_count",   32'(u_dut1.count),   32'd4);
    chk("bp_r_en",    32'(r_en[0]),        32'd0);
    chk("bp_head",    32'(md[0]),          32'h40);
    mr[0] = 1'b1; p0 = pop_cnt[0];
    for (int t = 0; t < 60 && pop_cnt[0] - p0 < 10; t++) tick(1);
    chk("bp_pops",    32'(pop_cnt[0] - p0), 32'd10);
    chk("bp_reads",   32'(acc_cnt[0]),      32'd10);

    // Empty flag: no reads while empty, then toggling every cycle
    force_empty[0] = 1'b1; f_base[0] = 8'h60; f_rd[0] = 0; f_wr[0] = 6; acc_cnt[0] = 0;
    tick(3);
    chk("empty_noacc", 32'(acc_cnt[0]), 32'd0);
    chk("empty_noval", 32'(mv[0]),      32'd0);
    p0 = pop_cnt[0];
    for (int t = 0; t < 60 && pop_cnt[0] - p0 < 6; t++) begin
      force_empty[0] = ~force_empty[0];
      tick(1);
    end
    force_empty[0] = 1'b1;
    chk("toggle_pops", 32'(pop_cnt[0] - p0), 32'd6);
    chk("toggle_rd",   32'(f_rd[0]),         32'd6);

    // Latency 2: first word after two pipe stages, then random m_ready
    force_empty[1] = 1'b0; f_base[1] = 8'hA0; f_rd[1] = 0; f_wr[1] = 16; mr[1] = 1'b0;
    p0 = pop_cnt[1];
    tick(1);
    chk("lat2_e1", 32'(mv[1]), 32'd0);
    tick(1);
    chk("lat2_e2", 32'(mv[1]), 32'd0);
    tick(1);
    chk("lat2_e3_valid", 32'(mv[1]), 32'd1);
    chk("lat2_e3_data",  32'(md[1]), 32'hA0);
    for (int t = 0; t < 300 && pop_cnt[1] - p0 < 16; t++) begin
      mr[1] = 1'($urandom_range(0, 1));
      tick(1);
    end
    chk("rand_pops", 32'(pop_cnt[1] - p0), 32'd16);
    chk("rand_rd",   32'(f_rd[1]),         32'd16);

    // Reset mid-stream with words in flight and buffered
    mr[1] = 1'b0; f_base[1] = 8'hC0; f_rd[1] = 0; f_wr[1] = 16;
    tick(4);
    chk("mid_inflight", 32'(u_dut2.inflight), 32'd2);
    chk("mid_count",    32'(u_dut2.count),    32'd2);
    rst = 1'b1;
    #1;
    chk("rst_inflight", 32'(u_dut2.inflight), 32'd0);
    chk("rst_count",    32'(u_dut2.count),    32'd0);
    chk("rst_pipe",     32'(u_dut2.u_pipe.vld_pipe[2:1]), 32'd0);
    chk("rst_valid2",   32'(mv[1]),   32'd0);
    chk("rst_ren2",     32'(r_en[1]), 32'd0);
    tick(1);
    chk("rst_hold_inflight", 32'(u_dut2.inflight), 32'd0);
    chk("rst_hold_data",     32'(md[1]),           32'd0);
    force_empty[1] = 1'b1;
    rst = 1'b0;
    tick(1);

`ifdef RD_STREAM_CNT_EN
    chk("cnt_reset", 32'(xc[0]), 32'd0);
    force_empty[0] = 1'b0; mr[0] = 1'b1; f_base[0] = 8'h00; f_rd[0] = 0; f_wr[0] = 70000;
    p0 = pop_cnt[0];
    for (int t = 0; t < 70000 && pop_cnt[0] - p0 < 65540; t++) tick(1);
    chk("cnt_pops", 32'(pop_cnt[0] - p0 >= 65540), 32'd1);
    chk("cnt_sat",  32'(xc[0]), 32'hFFFF);
    force_empty[0] = 1'b1;
    tick(6);
`endif

    tick(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
